// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: Moore-decoded selects and enables,
// stepped by the divider strobe, with a fetched-instruction counter for the LED view.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             SYS_reset,
  input  logic             step_en,
  input  logic [5:0]       opcode,
  output logic             pc_write,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB   = 4'd7,
    S_BEQ     = 4'd8,  S_BNE    = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JUMP    = 4'd12, S_ILLEGAL = 4'd13
  } state_e;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RT = 6'b000000,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_J = 6'b000010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             pcw_r, beq_r, bne_r, memw_r, irw_r, regw_r, ill_r;
  logic             wr_en;

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else if (step_en) begin
      state_q <= state_d;
      if (state_q == S_FETCH) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RT:        state_d = S_RTEX;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE:       state_d = S_BNE;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_RTEX:   state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore decode; raw strobes are gated below so each fires once per state visit.
  always_comb begin
    pcw_r = 1'b0; beq_r = 1'b0; bne_r = 1'b0; memw_r = 1'b0; irw_r = 1'b0;
    regw_r = 1'b0; ill_r = 1'b0;
    iord = 1'b0; reg_dst = 1'b0; mem_to_reg = 1'b0; alu_src_a = 1'b0;
    alu_src_b = 2'b00; alu_op = 2'b00; pc_source = 2'b00;
    case (state_q)
      S_FETCH:  begin irw_r = 1'b1; pcw_r = 1'b1; alu_src_b = 2'b01; end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEMRD:  iord = 1'b1;
      S_MEMWR:  begin iord = 1'b1; memw_r = 1'b1; end
      S_MEMWB:  begin regw_r = 1'b1; mem_to_reg = 1'b1; end
      S_RTEX:   begin alu_src_a = 1'b1; alu_op = 2'b10; end
      S_RTWB:   begin regw_r = 1'b1; reg_dst = 1'b1; end
      S_ADDIWB: regw_r = 1'b1;
      S_BEQ:    begin alu_src_a = 1'b1; alu_op = 2'b01; pc_source = 2'b01; beq_r = 1'b1; end
      S_BNE:    begin alu_src_a = 1'b1; alu_op = 2'b01; pc_source = 2'b01; bne_r = 1'b1; end
      S_JUMP:   begin pcw_r = 1'b1; pc_source = 2'b10; end
      S_ILLEGAL: ill_r = 1'b1;
      default:  ;
    endcase
  end

  assign wr_en      = step_en & ~SYS_reset;
  assign pc_write   = pcw_r  & wr_en;
  assign branch_eq  = beq_r  & wr_en;
  assign branch_ne  = bne_r  & wr_en;
  assign mem_write  = memw_r & wr_en;
  assign ir_write   = irw_r  & wr_en;
  assign reg_write  = regw_r & wr_en;
  assign illegal_op = ill_r  & wr_en;
  assign state      = state_q;
  assign instr_cnt  = cnt_q;

endmodule
